mac2phy_os_xmtr: RTL and testbench
==================================

// Module: mac2phy_os_xmtr
// PURPOSE
//  MAC-side ordered-set transmitter: serialises TS1, TS2 and SKP ordered sets one symbol per clk onto the
//  8-bit txdata/txdatak/en_n lane the PHY receiver consumes. The LTSSM issues OS requests with a valid/ready
//  handshake. A SKP scheduler inserts SKP sets at OS boundaries. Saturating sent-counters feed the LTSSM.
// PARAMETERS
//  SKP_INTERVAL  1180  clk cycles between scheduled SKP insertions while skp_en=1 (>=32)
//  TS_LEN        16    symbols per TS1/TS2 (fixed layout below; must be 16)
//  SKP_LEN       4     symbols per SKP OS: COM + (SKP_LEN-1) SKP symbols (>=3)
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   asynchronous active-low reset
//  req_valid    in   1   OS request valid
//  req_ready    out  1   request accepted when req_valid&&req_ready on a rising clk edge
//  req_type     in   2   01=TS1, 10=TS2, 11=SKP, 00=no-op
//  req_linkn    in   8   link number (ignored when req_link_pad=1)
//  req_link_pad in   1   1: send PAD as link number
//  req_lanen    in   8   lane number (ignored when req_lane_pad=1)
//  req_lane_pad in   1   1: send PAD as lane number
//  req_nfts     in   8   N_FTS field
//  req_dri      in   8   data rate identifier
//  req_tc       in   8   training control
//  skp_en       in   1   enables SKP interval timer
//  clr_ctrs     in   1   synchronous clear of sent-counters
//  txdata       out  8   symbol to PHY
//  txdatak      out  1   1 = K symbol
//  en_n         out  1   0 = txdata valid this cycle
//  busy         out  1   1 while an OS is being sent
//  ts1_sent     out  16  completed TS1 count, saturates at 16'hFFFF
//  ts2_sent     out  16  completed TS2 count, saturates at 16'hFFFF
// BEHAVIOUR
//  Symbols: COM=8'hBC K, PAD=8'hF7 K, SKP=8'h1C K, TS1ID=8'h4A D, TS2ID=8'h45 D.
//  TS layout: s0 COM; s1 link# (PAD,K if link_pad); s2 lane# (PAD,K if lane_pad); s3 nfts; s4 dri; s5 tc;
//   s6..s15 TS ID. All fields latched at acceptance; later input changes do not affect the OS in flight.
//  States: IDLE, SEND_TS, SEND_SKP. sym_idx counts 0..len-1; last symbol = boundary.
//  Reset: async; txdata=0, txdatak=0, en_n=1, busy=0, req_ready=0 while reset_n=0, counters=0, timer=0,
//   skp_pending=0, state IDLE. Reset mid-OS truncates it immediately; no partial count.
//  req_ready=1 when (IDLE or on boundary cycle) and skp_pending=0; else 0.
//  Latency: accepted request -> COM on txdata on the next cycle; back-to-back accept on the boundary gives
//   gapless output (no en_n=1 cycle between sets).
//  req_type=00 accepted as no-op: stays/returns IDLE, nothing sent.
//  IDLE outputs: en_n=1, txdata=0, txdatak=0, busy=0. busy=1 in SEND_TS/SEND_SKP.
//  SKP timer: counts while skp_en=1, held at 0 when skp_en=0; at SKP_INTERVAL-1 sets skp_pending (sticky)
//   and wraps to 0. A second expiry while pending is dropped (one SKP max).
//  skp_pending: at next boundary or in IDLE, SEND_SKP starts next cycle, ahead of any request;
//   cleared when SKP COM is driven. Explicit SKP request also clears skp_pending.
//  Counters: ts1_sent/ts2_sent +1 on boundary cycle of a TS1/TS2; saturate; clr_ctrs wins over same-cycle +1.
// TESTING
//  1 TS1 req linkn=8'h00 lane_pad=1 nfts=8'h1F dri=8'h02 tc=0 -> next cycle BC/K,00,F7/K,1F,02,00,10x4A; ts1_sent=1
//  2 TS2 accepted on TS1 boundary -> 32 contiguous symbols en_n=0, second set s6..s15=8'h45; ts2_sent=1
//  3 skp_en=1, SKP_INTERVAL=32, TS1 held valid -> after expiry, current TS finishes, BC,1C,1C,1C inserted, req_ready=0 meanwhile
//  4 ts1_sent=16'hFFFE, send 3 TS1 -> saturates FFFF; clr_ctrs on boundary of 4th -> 0
//  5 reset_n low at s7 of TS2 -> en_n=1, txdata=0 immediately; after release IDLE, ts2_sent=0
//  6 req_type=00 valid -> req_ready=1, en_n stays 1, no counter change

Source files
------------

// File: rtl/mac2phy_os_xmtr.sv
// mac2phy_os_xmtr: serialises TS1/TS2/SKP ordered sets onto the 8-bit PHY lane with SKP scheduling and sent-counters
module mac2phy_os_xmtr #(
    parameter int SKP_INTERVAL = 1180,
    parameter int TS_LEN       = 16,
    parameter int SKP_LEN      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [7:0]  req_linkn,
    input  logic        req_link_pad,
    input  logic [7:0]  req_lanen,
    input  logic        req_lane_pad,
    input  logic [7:0]  req_nfts,
    input  logic [7:0]  req_dri,
    input  logic [7:0]  req_tc,
    input  logic        skp_en,
    input  logic        clr_ctrs,
    output logic [7:0]  txdata,
    output logic        txdatak,
    output logic        en_n,
    output logic        busy,
    output logic [15:0] ts1_sent,
    output logic [15:0] ts2_sent
);
    localparam int IW = $clog2(TS_LEN > SKP_LEN ? TS_LEN : SKP_LEN);
    localparam int TW = $clog2(SKP_INTERVAL);
    localparam logic [IW-1:0] TS_LAST  = IW'(TS_LEN - 1);
    localparam logic [IW-1:0] SKP_LAST = IW'(SKP_LEN - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(SKP_INTERVAL - 1);
    localparam logic [7:0] COM = 8'hBC, PAD = 8'hF7, SKP = 8'h1C, TS1ID = 8'h4A, TS2ID = 8'h45;

    typedef enum logic [1:0] {IDLE, SEND_TS, SEND_SKP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [TW-1:0]   timer;
    logic            skp_pending, cur_ts2, l_link_pad, l_lane_pad;
    logic [7:0]      l_linkn, l_lanen, l_nfts, l_dri, l_tc;
    logic [15:0]     ts1_cnt, ts2_cnt;
    logic            ts_bnd, boundary, accept, expire;

    assign ts_bnd    = state == SEND_TS && idx == TS_LAST;
    assign boundary  = ts_bnd || (state == SEND_SKP && idx == SKP_LAST);
    assign req_ready = reset_n && (state == IDLE || boundary) && !skp_pending;
    assign accept    = req_valid && req_ready;
    assign expire    = skp_en && timer == T_LAST;
    assign ts1_sent  = ts1_cnt;
    assign ts2_sent  = ts2_cnt;

    // Next state: a pending SKP pre-empts requests at every OS boundary or in IDLE
    always_comb begin
        state_nx = state;
        idx_nx   = idx + 1'b1;
        if (state == IDLE || boundary) begin
            idx_nx = '0;
            if (skp_pending)
                state_nx = SEND_SKP;
            else if (accept)
                state_nx = req_type == 2'b11 ? SEND_SKP : req_type == 2'b00 ? IDLE : SEND_TS;
            else
                state_nx = IDLE;
        end
    end

    // State and symbol index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Field latch, SKP timer/pending flag and saturating sent-counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer       <= '0;
            skp_pending <= 1'b0;
            cur_ts2     <= 1'b0;
            l_linkn     <= '0;
            l_link_pad  <= 1'b0;
            l_lanen     <= '0;
            l_lane_pad  <= 1'b0;
            l_nfts      <= '0;
            l_dri       <= '0;
            l_tc        <= '0;
            ts1_cnt     <= '0;
            ts2_cnt     <= '0;
        end else begin
            if (accept && req_type[0] != req_type[1]) begin
                cur_ts2    <= req_type == 2'b10;
                l_linkn    <= req_linkn;
                l_link_pad <= req_link_pad;
                l_lanen    <= req_lanen;
                l_lane_pad <= req_lane_pad;
                l_nfts     <= req_nfts;
                l_dri      <= req_dri;
                l_tc       <= req_tc;
            end
            timer       <= (!skp_en || expire) ? '0 : timer + 1'b1;
            skp_pending <= ((state == SEND_SKP && idx == '0) || (accept && req_type == 2'b11)) ? 1'b0 :
                           expire ? 1'b1 : skp_pending;
            ts1_cnt     <= clr_ctrs ? '0 : (ts_bnd && !cur_ts2 && ts1_cnt != 16'hFFFF) ? ts1_cnt + 1'b1 : ts1_cnt;
            ts2_cnt     <= clr_ctrs ? '0 : (ts_bnd && cur_ts2 && ts2_cnt != 16'hFFFF) ? ts2_cnt + 1'b1 : ts2_cnt;
        end
    end

    // Lane outputs decoded from state and symbol index; IDLE drives an invalid zero symbol
    always_comb begin
        {txdatak, txdata} = 9'h000;
        en_n              = 1'b1;
        busy              = 1'b0;
        if (state == SEND_SKP) begin
            en_n              = 1'b0;
            busy              = 1'b1;
            {txdatak, txdata} = {1'b1, idx == '0 ? COM : SKP};
        end else if (state == SEND_TS) begin
            en_n = 1'b0;
            busy = 1'b1;
            case (idx)
                IW'(0):  {txdatak, txdata} = {1'b1, COM};
                IW'(1):  {txdatak, txdata} = l_link_pad ? {1'b1, PAD} : {1'b0, l_linkn};
                IW'(2):  {txdatak, txdata} = l_lane_pad ? {1'b1, PAD} : {1'b0, l_lanen};
                IW'(3):  {txdatak, txdata} = {1'b0, l_nfts};
                IW'(4):  {txdatak, txdata} = {1'b0, l_dri};
                IW'(5):  {txdatak, txdata} = {1'b0, l_tc};
                default: {txdatak, txdata} = {1'b0, cur_ts2 ? TS2ID : TS1ID};
            endcase
        end
    end
endmodule

// File: tb/tb_mac2phy_os_xmtr.sv
// tb_mac2phy_os_xmtr: table-driven and scoreboard checks of the ordered-set transmitter
module tb_mac2phy_os_xmtr;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_link_pad, req_lane_pad, skp_en, clr_ctrs;
    logic [1:0]  req_type;
    logic [7:0]  req_linkn, req_lanen, req_nfts, req_dri, req_tc, txdata;
    logic        txdatak, en_n, busy;
    logic [15:0] ts1_sent, ts2_sent;

    typedef struct {
        logic [1:0] typ;
        logic [7:0] linkn;
        logic       link_pad;
        logic [7:0] lanen;
        logic       lane_pad;
        logic [7:0] nfts;
        logic [7:0] dri;
        logic [7:0] tc;
        logic [7:0] id;
    } vec_t;

    int          vectors = 0;
    int          errors  = 0;
    bit          sb_on   = 1'b0;
    logic [8:0]  exp_q[$];
    logic [8:0]  e;
    logic [15:0] m_ts1, m_ts2;
    logic [10:0] rec[40];
    vec_t        tbl[5];
    vec_t        v;

    mac2phy_os_xmtr #(.SKP_INTERVAL(32)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_linkn(req_linkn), .req_link_pad(req_link_pad),
        .req_lanen(req_lanen), .req_lane_pad(req_lane_pad), .req_nfts(req_nfts),
        .req_dri(req_dri), .req_tc(req_tc), .skp_en(skp_en), .clr_ctrs(clr_ctrs),
        .txdata(txdata), .txdatak(txdatak), .en_n(en_n), .busy(busy),
        .ts1_sent(ts1_sent), .ts2_sent(ts2_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] exp_sym(input vec_t r, input int i);
        case (i)
            0:       return {1'b1, 8'hBC};
            1:       return r.link_pad ? {1'b1, 8'hF7} : {1'b0, r.linkn};
            2:       return r.lane_pad ? {1'b1, 8'hF7} : {1'b0, r.lanen};
            3:       return {1'b0, r.nfts};
            4:       return {1'b0, r.dri};
            5:       return {1'b0, r.tc};
            default: return {1'b0, r.id};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb_on && reset_n) begin
            vectors++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (en_n !== 1'b0 || {txdatak, txdata} !== e) begin
                    errors++;
                    $display("FAIL sym: got en_n=%b k/data=%h expected en_n=0 k/data=%h", en_n, {txdatak, txdata}, e);
                end
            end else if (en_n !== 1'b1) begin
                errors++;
                $display("FAIL idle_lane: got en_n=%b expected 1", en_n);
            end
        end
    end

    task automatic issue(input vec_t r);
        @(negedge clk);
        req_type     = r.typ;
        req_linkn    = r.linkn;
        req_link_pad = r.link_pad;
        req_lanen    = r.lanen;
        req_lane_pad = r.lane_pad;
        req_nfts     = r.nfts;
        req_dri      = r.dri;
        req_tc       = r.tc;
        req_valid    = 1'b1;
        for (int t = 0; t < 64 && !req_ready; t++) @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_linkn    = 8'($urandom);
        req_link_pad = 1'($urandom);
        req_lanen    = 8'($urandom);
        req_lane_pad = 1'($urandom);
        req_nfts     = 8'($urandom);
        req_dri      = 8'($urandom);
        req_tc       = 8'($urandom);
        if (r.typ == 2'b01 || r.typ == 2'b10) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(exp_sym(r, i));
            if (r.typ == 2'b01) m_ts1 = m_ts1 == 16'hFFFF ? m_ts1 : m_ts1 + 16'd1;
            else m_ts2 = m_ts2 == 16'hFFFF ? m_ts2 : m_ts2 + 16'd1;
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_ctrs(input string name);
        chk({name, "_ts1"}, 32'(ts1_sent), 32'(m_ts1));
        chk({name, "_ts2"}, 32'(ts2_sent), 32'(m_ts2));
    endtask

    initial begin
        tbl[0] = '{2'b01, 8'h05, 1'b0, 8'h03, 1'b0, 8'h80, 8'h06, 8'h01, 8'h4A};
        tbl[1] = '{2'b10, 8'h00, 1'b1, 8'h0A, 1'b0, 8'hFF, 8'h04, 8'h02, 8'h45};
        tbl[2] = '{2'b10, 8'h7E, 1'b1, 8'h7F, 1'b1, 8'h00, 8'hFF, 8'h0F, 8'h45};
        tbl[3] = '{2'b01, 8'hAA, 1'b0, 8'h55, 1'b1, 8'h3C, 8'h02, 8'h08, 8'h4A};
        tbl[4] = '{2'b10, 8'h12, 1'b0, 8'h34, 1'b0, 8'h56, 8'h78, 8'h9A, 8'h45};
        {req_valid, req_link_pad, req_lane_pad, skp_en, clr_ctrs} = '0;
        {req_type, req_linkn, req_lanen, req_nfts, req_dri, req_tc} = '0;
        m_ts1   = '0;
        m_ts2   = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_en_n", 32'(en_n), 32'd1);
        chk("rst_txdata", 32'({txdatak, txdata}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk_ctrs("rst");
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        sb_on = 1'b1;

        // single TS1 with PAD lane
        v = '{2'b01, 8'h00, 1'b0, 8'h00, 1'b1, 8'h1F, 8'h02, 8'h00, 8'h4A};
        issue(v);
        wait_idle();
        chk_ctrs("t1");

        // table vectors issued back-to-back, gapless across boundaries
        for (int i = 0; i < 5; i++) issue(tbl[i]);
        wait_idle();
        chk_ctrs("table");

        // no-op request
        v = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        issue(v);
        repeat (3) @(negedge clk);
        chk("noop_busy", 32'(busy), 32'd0);
        chk_ctrs("noop");

        // saturation and clear-over-increment
        @(negedge clk);
        force dut.ts1_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.ts1_cnt;
        m_ts1 = 16'hFFFE;
        @(negedge clk);
        chk_ctrs("preload");
        v = tbl[3];
        repeat (3) issue(v);
        wait_idle();
        chk_ctrs("sat");
        for (int n = 0; n < 2; n++) begin
            issue(v);
            repeat (16) @(negedge clk);
            clr_ctrs = 1'b1;
            @(posedge clk);
            #1;
            clr_ctrs = 1'b0;
            m_ts1 = '0;
            m_ts2 = '0;
            wait_idle();
            chk_ctrs($sformatf("clr%0d", n));
        end

        // SKP insertion with TS1 held valid
        sb_on = 1'b0;
        v = tbl[0];
        @(negedge clk);
        {req_type, req_linkn, req_link_pad, req_lanen, req_lane_pad} = {v.typ, v.linkn, v.link_pad, v.lanen, v.lane_pad};
        {req_nfts, req_dri, req_tc} = {v.nfts, v.dri, v.tc};
        req_valid = 1'b1;
        skp_en    = 1'b1;
        for (int p = 0; p < 40; p++) begin
            @(negedge clk);
            rec[p] = {req_ready, en_n, txdatak, txdata};
        end
        req_valid = 1'b0;
        skp_en    = 1'b0;
        for (int p = 0; p < 40; p++) begin
            if (p < 32)
                chk($sformatf("skp_seq%0d", p), 32'(rec[p]), 32'({p % 16 == 15 && p != 31, 1'b0, exp_sym(v, p % 16)}));
            else if (p < 36)
                chk($sformatf("skp_seq%0d", p), 32'(rec[p]), 32'({p == 35, 1'b0, 1'b1, p == 32 ? 8'hBC : 8'h1C}));
            else
                chk($sformatf("skp_seq%0d", p), 32'(rec[p]), 32'({1'b0, 1'b0, exp_sym(v, p - 36)}));
        end
        for (int t = 0; t < 100 && busy; t++) @(negedge clk);
        chk("skp_done", 32'(busy), 32'd0);

        // reset in the middle of a TS2
        issue(tbl[4]);
        repeat (8) @(negedge clk);
        chk("mid_s7", 32'({en_n, txdatak, txdata}), 32'({1'b0, 1'b0, 8'h45}));
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_en_n", 32'(en_n), 32'd1);
        chk("rst_mid_txdata", 32'({txdatak, txdata}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        m_ts1 = '0;
        m_ts2 = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_en_n", 32'(en_n), 32'd1);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk_ctrs("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
